// File: rtl/dmem_arbiter_pkg.sv
// Shared types and address-check constants for the two-port data memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LAST0 = 2'd1,
    LAST1 = 2'd2
  } arb_state_e;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;
  localparam int BYTE_OFF_W = $clog2(WORD_BYTES);
  localparam int WORD_IDX_W = ADDR_W - BYTE_OFF_W;

  // Word-aligned and inside the memory
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                   input int unsigned       mem_words);
    return (addr[BYTE_OFF_W-1:0] == '0) &&
           ({{BYTE_OFF_W{1'b0}}, addr[ADDR_W-1:BYTE_OFF_W]} < ADDR_W'(mem_words));
  endfunction

  function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return {{BYTE_OFF_W{1'b0}}, addr[ADDR_W-1:BYTE_OFF_W]};
  endfunction

endpackage

// File: rtl/dmem_resp_reg.sv
// One-cycle response register for a single arbiter port: rvalid, rdata and err.
module dmem_resp_reg
  import dmem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              gnt,
  input  logic              rd_en,
  input  logic              ok,
  input  logic [ADDR_W-1:0] mem_rd,
  output logic              rvalid,
  output logic [ADDR_W-1:0] rdata,
  output logic              err
);

  logic rvalid_q;
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata    <= '0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt && !ok;
      rdata    <= (gnt && rd_en) ? mem_rd : '0;
    end
  end

  // A response already in flight when reset arrives is dropped immediately
  assign rvalid = rvalid_q & ~rst;
  assign err    = err_q & ~rst;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: port 0 has priority, port 1 is forced through
// after STARVE_LIMIT consecutive denied cycles.
//
// state | meaning
// IDLE  | no grant in the previous cycle
// LAST0 | port 0 was granted in the previous cycle
// LAST1 | port 1 was granted in the previous cycle
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int MEM_WORDS    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [ADDR_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [ADDR_W-1:0] p0_rdata,
  output logic [ADDR_W-1:0] p1_rdata,
  output logic              p0_err,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [ADDR_W-1:0] mem_writeData,
  output logic              mem_writeEnable,
  input  logic [ADDR_W-1:0] mem_RD,
  output arb_state_e        state
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             p1_force;
  logic             p0_ok;
  logic             p1_ok;

  assign p0_ok    = addr_ok(p0_addr, MEM_WORDS);
  assign p1_ok    = addr_ok(p1_addr, MEM_WORDS);
  assign p1_force = p1_req && (starve_cnt == CNT_MAX);
  assign p0_gnt   = !rst && p0_req && !p1_force;
  assign p1_gnt   = !rst && p1_req && (!p0_req || p1_force);

  always_comb begin
    mem_A           = '0;
    mem_writeData   = '0;
    mem_writeEnable = 1'b0;
    if (p0_gnt) begin
      mem_A           = word_idx(p0_addr);
      mem_writeData   = p0_wdata;
      mem_writeEnable = p0_we && p0_ok;
    end else if (p1_gnt) begin
      mem_A           = word_idx(p1_addr);
      mem_writeData   = p1_wdata;
      mem_writeEnable = p1_we && p1_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      state      <= IDLE;
    end else begin
      if (!p1_req || p1_gnt) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      if (p0_gnt) begin
        state <= LAST0;
      end else if (p1_gnt) begin
        state <= LAST1;
      end else begin
        state <= IDLE;
      end
    end
  end

  dmem_resp_reg u_resp0 (
    .clk    (clk),
    .rst    (rst),
    .gnt    (p0_gnt),
    .rd_en  (!p0_we && p0_ok),
    .ok     (p0_ok),
    .mem_rd (mem_RD),
    .rvalid (p0_rvalid),
    .rdata  (p0_rdata),
    .err    (p0_err)
  );

  dmem_resp_reg u_resp1 (
    .clk    (clk),
    .rst    (rst),
    .gnt    (p1_gnt),
    .rd_en  (!p1_we && p1_ok),
    .ok     (p1_ok),
    .mem_rd (mem_RD),
    .rvalid (p1_rvalid),
    .rdata  (p1_rdata),
    .err    (p1_err)
  );

endmodule
